// File: rtl/controle_clima.sv
// Climate controller: turns DHT11 samples into a committed temperature level,
// a slowly ramped fan duty, a dehumidifier relay with minimum on-time, and a fail-safe.
module controle_clima #(
  parameter int HISTERESE     = 1,
  parameter int PERIODO_RAMPA = 50_000_000,
  parameter int MIN_RELE      = 250_000_000,
  parameter int MAX_ERROS     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medida_valida,
  input  logic        erro_medida,
  input  logic [15:0] temperatura,
  input  logic [15:0] umidade,
  input  logic [15:0] lim_temp1,
  input  logic [15:0] lim_temp2,
  input  logic [15:0] lim_temp3,
  input  logic [15:0] lim_temp4,
  input  logic [15:0] lim_umidade,
  output logic [2:0]  nivel_temperatura,
  output logic [2:0]  duty_ventoinha,
  output logic        rele,
  output logic        servo_habilita,
  output logic        falha,
  output logic [3:0]  db_estado
);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    AVALIA = 2'd1,
    RAMPA  = 2'd2,
    FALHA  = 2'd3
  } estado_t;

  localparam logic [7:0]  MAX_E     = 8'(MAX_ERROS);
  localparam logic [31:0] RAMPA_FIM = 32'(PERIODO_RAMPA - 1);
  localparam logic [31:0] RELE_MIN  = 32'(MIN_RELE);
  localparam logic [8:0]  HIST      = 9'(HISTERESE);

  estado_t     estado_reg, estado_next;
  logic [7:0]  temp_reg, temp_next;
  logic [7:0]  umid_reg, umid_next;
  logic [7:0]  lim_umid_reg, lim_umid_next;
  logic [7:0]  lim_reg [4];
  logic [7:0]  lim_next [4];
  logic [7:0]  lim_in [4];
  logic [2:0]  nivel_reg, nivel_next;
  logic [2:0]  duty_reg, duty_next;
  logic        rele_reg, rele_next;
  logic        falha_reg, falha_next;
  logic        pendente_reg, pendente_next;
  logic [7:0]  erro_cnt_reg, erro_cnt_next;
  logic [31:0] rampa_cnt_reg, rampa_cnt_next;
  logic [31:0] rele_cnt_reg, rele_cnt_next;

  logic [3:0]  acima, acima_hist;
  logic [8:0]  temp_hist, umid_hist;
  logic [2:0]  sobe, desce, nivel_novo, duty_passo;
  logic        captura, fim_rampa;
  logic        unused_bytes;

  // Only the integer byte of each sample/limit carries information.
  assign unused_bytes = ^{temperatura[7:0], umidade[7:0], lim_temp1[7:0], lim_temp2[7:0],
                          lim_temp3[7:0], lim_temp4[7:0], lim_umidade[7:0]};

  assign lim_in[0] = lim_temp1[15:8];
  assign lim_in[1] = lim_temp2[15:8];
  assign lim_in[2] = lim_temp3[15:8];
  assign lim_in[3] = lim_temp4[15:8];

  assign temp_hist = {1'b0, temp_reg} + HIST;
  assign umid_hist = {1'b0, umid_reg} + HIST;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_limiar
      assign acima[gi]      = {1'b0, temp_reg} >= {1'b0, lim_reg[gi]};
      assign acima_hist[gi] = temp_hist >= {1'b0, lim_reg[gi]};
    end
  endgenerate

  always_comb begin
    sobe  = '0;
    desce = '0;
    for (int i = 0; i < 4; i++) begin
      sobe  = sobe + 3'(acima[i]);
      desce = desce + 3'(acima_hist[i]);
    end
  end

  // Level rises on the plain count, falls only once the hysteresis-widened count drops.
  always_comb begin
    nivel_novo = nivel_reg;
    if (sobe > nivel_reg)
      nivel_novo = sobe;
    else if (desce < nivel_reg)
      nivel_novo = desce;
  end

  assign duty_passo = (duty_reg < nivel_reg) ? duty_reg + 3'd1 : duty_reg - 3'd1;
  assign captura    = medida_valida && (estado_reg != AVALIA);

  always_comb begin
    estado_next    = estado_reg;
    temp_next      = temp_reg;
    umid_next      = umid_reg;
    lim_umid_next  = lim_umid_reg;
    for (int i = 0; i < 4; i++) lim_next[i] = lim_reg[i];
    nivel_next     = nivel_reg;
    duty_next      = duty_reg;
    rele_next      = rele_reg;
    falha_next     = falha_reg;
    pendente_next  = pendente_reg;
    erro_cnt_next  = erro_cnt_reg;
    rampa_cnt_next = rampa_cnt_reg;
    rele_cnt_next  = (rele_cnt_reg != '1) ? rele_cnt_reg + 32'd1 : rele_cnt_reg;
    fim_rampa      = 1'b0;

    if (medida_valida)
      erro_cnt_next = '0;
    else if (erro_medida && estado_reg != FALHA && erro_cnt_reg < MAX_E)
      erro_cnt_next = erro_cnt_reg + 8'd1;

    if (captura) begin
      temp_next     = temperatura[15:8];
      umid_next     = umidade[15:8];
      lim_umid_next = lim_umidade[15:8];
      for (int i = 0; i < 4; i++) lim_next[i] = lim_in[i];
    end

    case (estado_reg)
      ESPERA: begin
        if (medida_valida) estado_next = AVALIA;
      end
      AVALIA: begin
        nivel_next     = nivel_novo;
        rampa_cnt_next = '0;
        estado_next    = (duty_reg != nivel_novo) ? RAMPA : ESPERA;
        if (!rele_reg && umid_reg > lim_umid_reg) begin
          rele_next     = 1'b1;
          rele_cnt_next = '0;
        end else if (rele_reg && umid_hist <= {1'b0, lim_umid_reg} && rele_cnt_reg >= RELE_MIN) begin
          rele_next = 1'b0;
        end
      end
      RAMPA: begin
        if (medida_valida) pendente_next = 1'b1;
        if (duty_reg == nivel_reg) begin
          fim_rampa = 1'b1;
        end else if (rampa_cnt_reg >= RAMPA_FIM) begin
          rampa_cnt_next = '0;
          duty_next      = duty_passo;
          fim_rampa      = (duty_passo == nivel_reg);
        end else begin
          rampa_cnt_next = rampa_cnt_reg + 32'd1;
        end
        // A sample captured mid-ramp is evaluated as soon as the ramp lands.
        if (fim_rampa) begin
          estado_next   = (pendente_reg || medida_valida) ? AVALIA : ESPERA;
          pendente_next = 1'b0;
        end
      end
      FALHA: begin
        if (medida_valida) begin
          falha_next  = 1'b0;
          estado_next = AVALIA;
        end
      end
      default: estado_next = ESPERA;
    endcase

    if (erro_cnt_reg >= MAX_E && estado_reg != FALHA) begin
      estado_next   = FALHA;
      duty_next     = 3'd4;
      nivel_next    = 3'd4;
      rele_next     = 1'b0;
      falha_next    = 1'b1;
      pendente_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg    <= ESPERA;
      temp_reg      <= '0;
      umid_reg      <= '0;
      lim_umid_reg  <= '0;
      for (int i = 0; i < 4; i++) lim_reg[i] <= '0;
      nivel_reg     <= '0;
      duty_reg      <= '0;
      rele_reg      <= 1'b0;
      falha_reg     <= 1'b0;
      pendente_reg  <= 1'b0;
      erro_cnt_reg  <= '0;
      rampa_cnt_reg <= '0;
      rele_cnt_reg  <= '0;
    end else begin
      estado_reg    <= estado_next;
      temp_reg      <= temp_next;
      umid_reg      <= umid_next;
      lim_umid_reg  <= lim_umid_next;
      for (int i = 0; i < 4; i++) lim_reg[i] <= lim_next[i];
      nivel_reg     <= nivel_next;
      duty_reg      <= duty_next;
      rele_reg      <= rele_next;
      falha_reg     <= falha_next;
      pendente_reg  <= pendente_next;
      erro_cnt_reg  <= erro_cnt_next;
      rampa_cnt_reg <= rampa_cnt_next;
      rele_cnt_reg  <= rele_cnt_next;
    end
  end

  assign nivel_temperatura = nivel_reg;
  assign duty_ventoinha    = duty_reg;
  assign rele              = rele_reg;
  assign falha             = falha_reg;
  assign servo_habilita    = (nivel_reg >= 3'd2);
  assign db_estado         = {2'b00, estado_reg};

endmodule

// File: tb/tb_controle_clima.sv
// Randomized bench for controle_clima: a transaction-level model predicts level,
// relay and the fan duty trajectory as a function of elapsed cycles.
module tb_controle_clima;
  localparam int H  = 1;
  localparam int PR = 4;
  localparam int MR = 20;
  localparam int ME = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        medida_valida = 1'b0;
  logic        erro_medida = 1'b0;
  logic [15:0] temperatura = '0, umidade = '0;
  logic [15:0] lim_temp1 = '0, lim_temp2 = '0, lim_temp3 = '0, lim_temp4 = '0, lim_umidade = '0;
  logic [2:0]  nivel_temperatura, duty_ventoinha;
  logic        rele, servo_habilita, falha;
  logic [3:0]  db_estado;

  controle_clima #(.HISTERESE(H), .PERIODO_RAMPA(PR), .MIN_RELE(MR), .MAX_ERROS(ME)) dut (
    .clock(clock), .reset(reset), .medida_valida(medida_valida), .erro_medida(erro_medida),
    .temperatura(temperatura), .umidade(umidade),
    .lim_temp1(lim_temp1), .lim_temp2(lim_temp2), .lim_temp3(lim_temp3), .lim_temp4(lim_temp4),
    .lim_umidade(lim_umidade), .nivel_temperatura(nivel_temperatura), .duty_ventoinha(duty_ventoinha),
    .rele(rele), .servo_habilita(servo_habilita), .falha(falha), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int erros  = 0;
  int lim_m [4];
  int lu_m;
  int m_nivel = 0, m_duty = 0, m_rele = 0, m_c_on = 0;

  task automatic verifica(input string tag, input int obs, input int esp);
    checks++;
    if (obs != esp) begin
      erros++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic limites(input int a, input int b, input int c, input int d, input int u);
    lim_m[0] = a; lim_m[1] = b; lim_m[2] = c; lim_m[3] = d; lu_m = u;
    lim_temp1   = {8'(a), 8'($urandom)};
    lim_temp2   = {8'(b), 8'($urandom)};
    lim_temp3   = {8'(c), 8'($urandom)};
    lim_temp4   = {8'(d), 8'($urandom)};
    lim_umidade = {8'(u), 8'($urandom)};
  endtask

  // Called on the falling edge inside the one-cycle evaluation state.
  task automatic avaliar(input int t, input int u, input int inj_k, input int inj_t,
                         input int inj_u, output bit pend);
    int up, down, start, diff, dir, cyc_av;
    verifica("estado_avalia", db_estado, 1);
    cyc_av = cyc;
    up = 0; down = 0;
    for (int i = 0; i < 4; i++) begin
      if (t >= lim_m[i]) up++;
      if (t + H >= lim_m[i]) down++;
    end
    if (up > m_nivel) m_nivel = up;
    else if (down < m_nivel) m_nivel = down;
    if (m_rele == 0 && u > lu_m) begin
      m_rele = 1;
      m_c_on = cyc_av + 1;
    end else if (m_rele == 1 && u + H <= lu_m && cyc_av - m_c_on >= MR) begin
      m_rele = 0;
    end
    start = m_duty;
    dir   = (m_nivel > start) ? 1 : -1;
    diff  = dir * (m_nivel - start);
    pend  = 1'b0;
    @(negedge clock);
    verifica("nivel", nivel_temperatura, m_nivel);
    verifica("rele", rele, m_rele);
    verifica("servo", servo_habilita, (m_nivel >= 2) ? 1 : 0);
    verifica("falha_livre", falha, 0);
    if (diff == 0) begin
      verifica("estado_sem_rampa", db_estado, 0);
    end else begin
      for (int k = 0; k < PR * diff; k++) begin
        verifica("estado_rampa", db_estado, 2);
        verifica("duty_rampa", duty_ventoinha, start + dir * (k / PR));
        if (k == inj_k) begin
          temperatura   = {8'(inj_t), 8'($urandom)};
          umidade       = {8'(inj_u), 8'($urandom)};
          medida_valida = 1'b1;
          pend          = 1'b1;
        end
        @(negedge clock);
        medida_valida = 1'b0;
      end
      m_duty = m_nivel;
      verifica("duty_final", duty_ventoinha, m_duty);
      verifica("estado_pos_rampa", db_estado, pend ? 1 : 0);
    end
  endtask

  task automatic medir(input int t, input int u, input bit erro_junto, input int inj_k,
                       input int inj_t, input int inj_u);
    bit pend;
    temperatura   = {8'(t), 8'($urandom)};
    umidade       = {8'(u), 8'($urandom)};
    medida_valida = 1'b1;
    erro_medida   = erro_junto;
    @(negedge clock);
    medida_valida = 1'b0;
    erro_medida   = 1'b0;
    avaliar(t, u, inj_k, inj_t, inj_u, pend);
    if (pend) avaliar(inj_t, inj_u, -1, 0, 0, pend);
    $display("medida T=%0d U=%0d nivel=%0d duty=%0d rele=%0d estado=%0d",
             t, u, nivel_temperatura, duty_ventoinha, rele, db_estado);
  endtask

  task automatic pulsos_erro(input int n);
    for (int i = 0; i < n; i++) begin
      erro_medida = 1'b1;
      @(negedge clock);
      erro_medida = 1'b0;
    end
  endtask

  // n pulses that complete the error count; fail-safe follows one cycle later.
  task automatic entra_falha(input int n);
    pulsos_erro(n);
    verifica("antes_falha", db_estado, 0);
    @(negedge clock);
    m_duty = 4; m_nivel = 4; m_rele = 0;
    verifica("estado_falha", db_estado, 3);
    verifica("duty_falha", duty_ventoinha, 4);
    verifica("nivel_falha", nivel_temperatura, 4);
    verifica("rele_falha", rele, 0);
    verifica("falha_ativa", falha, 1);
    verifica("servo_falha", servo_habilita, 1);
    $display("falha-segura duty=%0d nivel=%0d", duty_ventoinha, nivel_temperatura);
  endtask

  task automatic reset_no_meio();
    int t;
    t = (m_nivel < 4) ? 60 : 0;
    temperatura   = {8'(t), 8'h00};
    umidade       = {8'(lu_m + 5), 8'h00};
    medida_valida = 1'b1;
    @(negedge clock);
    medida_valida = 1'b0;
    repeat (3) @(negedge clock);
    verifica("rampa_antes_reset", db_estado, 2);
    #2 reset = 1'b1;
    #1;
    verifica("rst_nivel", nivel_temperatura, 0);
    verifica("rst_duty", duty_ventoinha, 0);
    verifica("rst_rele", rele, 0);
    verifica("rst_falha", falha, 0);
    verifica("rst_servo", servo_habilita, 0);
    verifica("rst_estado", db_estado, 0);
    @(negedge clock);
    reset = 1'b0;
    m_nivel = 0; m_duty = 0; m_rele = 0;
    @(negedge clock);
    verifica("pos_reset_estado", db_estado, 0);
    $display("reset no meio da rampa T=%0d", t);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r, t, u, g, ik;
    limites(25, 28, 31, 34, 70);
    repeat (3) @(negedge clock);
    verifica("reset_nivel", nivel_temperatura, 0);
    verifica("reset_duty", duty_ventoinha, 0);
    verifica("reset_rele", rele, 0);
    verifica("reset_falha", falha, 0);
    verifica("reset_servo", servo_habilita, 0);
    verifica("reset_estado", db_estado, 0);
    reset = 1'b0;
    @(negedge clock);

    medir(29, 60, 1'b0, -1, 0, 0);
    verifica("t29_nivel2", nivel_temperatura, 2);
    medir(27, 60, 1'b0, -1, 0, 0);
    verifica("t27_mantem2", nivel_temperatura, 2);
    medir(26, 60, 1'b0, -1, 0, 0);
    verifica("t26_nivel1", duty_ventoinha, 1);

    medir(26, 71, 1'b0, -1, 0, 0);
    verifica("u71_liga", rele, 1);
    repeat (3) @(negedge clock);
    medir(26, 69, 1'b0, -1, 0, 0);
    verifica("u69_cedo", rele, 1);
    repeat (25) @(negedge clock);
    medir(26, 69, 1'b0, -1, 0, 0);
    verifica("u69_desliga", rele, 0);
    medir(26, 70, 1'b0, -1, 0, 0);
    verifica("u70_inalterado", rele, 0);

    medir(29, 60, 1'b0, 2, 35, 60);
    verifica("pendente_nivel4", nivel_temperatura, 4);

    pulsos_erro(2);
    medir(33, 60, 1'b1, -1, 0, 0);
    pulsos_erro(2);
    repeat (2) @(negedge clock);
    verifica("contador_zerado", db_estado, 0);
    entra_falha(1);
    pulsos_erro(1);
    verifica("erro_ignorado_falha", db_estado, 3);
    medir(20, 60, 1'b0, -1, 0, 0);
    verifica("saida_falha_duty0", duty_ventoinha, 0);

    medir(29, 75, 1'b0, -1, 0, 0);
    reset_no_meio();
    limites(25, 28, 31, 34, 70);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        entra_falha(ME);
        medir($urandom_range(15, 45), $urandom_range(lu_m - 3, lu_m + 3), 1'b0, -1, 0, 0);
      end else if (r == 1) begin
        reset_no_meio();
      end else begin
        if ($urandom_range(0, 2) == 0)
          limites($urandom_range(20, 40), $urandom_range(20, 40), $urandom_range(20, 40),
                  $urandom_range(20, 40), $urandom_range(60, 80));
        pulsos_erro($urandom_range(0, ME - 1));
        g = $urandom_range(0, 25);
        repeat (g) @(negedge clock);
        t  = $urandom_range(15, 45);
        u  = $urandom_range(lu_m - 3, lu_m + 3);
        ik = ($urandom_range(0, 2) == 0) ? $urandom_range(0, PR - 1) : -1;
        medir(t, u, 1'(($urandom_range(0, 3) == 0) ? 1 : 0), ik,
              $urandom_range(15, 45), $urandom_range(lu_m - 3, lu_m + 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end
endmodule

// File: doc/controle_clima.md
CONTROLE_CLIMA -- requirements
Module: controle_clima

Interface
REQ-001 SHALL have parameter HISTERESE, default 1, hysteresis in whole °C / %RH units.
REQ-002 SHALL have parameter PERIODO_RAMPA, default 50_000_000, clock cycles per fan duty step.
REQ-003 SHALL have parameter MIN_RELE, default 250_000_000, minimum relay on-time in clock cycles.
REQ-004 SHALL have parameter MAX_ERROS, default 3, consecutive measurement errors before fail-safe.
REQ-005 SHALL have ports, one clock and asynchronous active-high reset:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- medida_valida  in  1  one-cycle pulse, new DHT11 sample valid
- erro_medida  in  1  one-cycle pulse, DHT11 read failed
- temperatura  in  16  [15:8] integer °C, [7:0] ignored
- umidade  in  16  [15:8] integer %RH, [7:0] ignored
- lim_temp1..lim_temp4  in  16 each  temperature thresholds, [15:8] used
- lim_umidade  in  16  humidity threshold, [15:8] used
- nivel_temperatura  out  3  committed level 0..4
- duty_ventoinha  out  3  fan duty step 0..4 to PWM generator
- rele  out  1  1 = dehumidifier relay on
- servo_habilita  out  1  1 = servo sweep enabled
- falha  out  1  fail-safe active
- db_estado  out  4  FSM state code

Function
REQ-006 SHALL implement FSM: ESPERA=0, AVALIA=1, RAMPA=2, FALHA=3; other codes unused; illegal state -> ESPERA.
REQ-007 SHALL, in ESPERA/RAMPA/FALHA, capture temperatura, umidade, all limits into internal registers on medida_valida.
REQ-008 SHALL treat medida_valida and erro_medida in same cycle as medida_valida only.
REQ-009 SHALL clear error counter on medida_valida; increment on erro_medida, saturating at MAX_ERROS.
REQ-010 SHALL go ESPERA -> AVALIA the cycle after medida_valida; AVALIA lasts exactly 1 cycle, then RAMPA if duty != new level, else ESPERA.
REQ-011 SHALL compute in AVALIA, on captured [15:8] values, 9-bit unsigned (no overflow): up = count of i with T >= lim_i; down = count of i with T + HISTERESE >= lim_i.
REQ-012 SHALL set nivel = up if up > nivel; nivel = down if down < nivel; else hold; limits need not be monotonic.
REQ-013 SHALL, in RAMPA, move duty_ventoinha one step toward nivel each PERIODO_RAMPA cycles; first step PERIODO_RAMPA cycles after RAMPA entry; -> ESPERA when equal.
REQ-014 SHALL, on medida_valida during RAMPA, set pending flag; on ramp completion -> AVALIA if pending (flag cleared), else ESPERA; ramp timer not restarted by capture.
REQ-015 SHALL evaluate relay in AVALIA: off->on if U > lim_umidade; on->off only if U + HISTERESE <= lim_umidade and on-timer >= MIN_RELE.
REQ-016 SHALL restart on-timer at relay off->on; count saturating.
REQ-017 SHALL drive servo_habilita = 1 iff nivel_temperatura >= 2 (combinational from nivel).
REQ-018 SHALL enter FALHA from any state the cycle after error counter reaches MAX_ERROS: duty_ventoinha=4, nivel=4, rele=0, falha=1, pending cleared.
REQ-019 SHALL in FALHA ignore erro_medida; on medida_valida clear falha, -> AVALIA; ramp from duty 4 per REQ-013.
REQ-020 SHALL change duty_ventoinha by at most one step per PERIODO_RAMPA except on FALHA entry.

Reset
REQ-021 SHALL on reset, asynchronously: state ESPERA, nivel_temperatura=0, duty_ventoinha=0, rele=0, falha=0, servo_habilita=0, error counter, ramp timer, relay timer, pending flag, captured registers all 0.
REQ-022 SHALL abort any ramp or fail-safe on reset mid-operation; no residual state.

Verification (PERIODO_RAMPA=4, MIN_RELE=20, MAX_ERROS=3, HISTERESE=1; limits 25,28,31,34 °C; lim_umidade 70)
REQ-023 SHALL cover: T=29 pulse -> AVALIA 1 cycle, nivel=2, servo_habilita=1, duty 0->1->2 at +4/+8 cycles in RAMPA, then ESPERA.
REQ-024 SHALL cover hysteresis: from nivel 2, T=27 -> nivel holds 2; T=26 -> nivel 1, duty steps down once.
REQ-025 SHALL cover relay: U=71 -> rele=1; U=69 after 5 cycles -> rele stays 1; U=69 after timer >= 20 -> rele=0; U=70 -> unchanged.
REQ-026 SHALL cover errors: 3 erro_medida pulses -> FALHA, duty=4, rele=0, falha=1; error+valid same cycle -> counter 0; valid with T=20 -> duty ramps 4..0.
REQ-027 SHALL cover: medida_valida during RAMPA -> pending, AVALIA after ramp; reset asserted mid-RAMPA -> all outputs 0 same cycle.
